// File: rtl/i2c_rx_ctrl.sv
// I2C slave receive controller.
// Samples pre-synchronised SCL/SDA and detects START, repeated START and STOP.
// Matches the 7-bit address against NUM_ADDR programmable slots.
// Receives data bytes and drives ACK/NACK after a programmable hold delay.
// Each accepted byte is handed over on a valid/ready interface.
module i2c_rx_ctrl #(
   parameter int NUM_ADDR   = 2,
   parameter int HOLD_CNT_W = 4,
   parameter int IDX_W      = 1
) (
   input  logic                    clk,
   input  logic                    rst_an,
   input  logic                    enable,
   input  logic                    scl_s,
   input  logic                    sda_s,
   input  logic [7*NUM_ADDR-1:0]   addr_cfg,
   input  logic [NUM_ADDR-1:0]     addr_en,
   input  logic [HOLD_CNT_W-1:0]   hold_cycles,
   output logic                    sda_oe,
   output logic                    active,
   output logic [7:0]              rx_data,
   output logic                    rx_valid,
   input  logic                    rx_ready,
   output logic                    rx_first,
   output logic [IDX_W-1:0]        match_idx,
   output logic                    rd_req,
   output logic                    overrun
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR_LO, ST_ADDR_HI, ST_AACK_LO, ST_AACK_HI,
      ST_DATA_LO, ST_DATA_HI, ST_DACK_LO, ST_DACK_HI, ST_IGNORE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_scl_q, r_sda_q;
   logic [2:0]            r_bit_cnt;
   logic [7:0]            r_shift;
   logic                  r_rw;
   logic [HOLD_CNT_W-1:0] r_hold_cnt;
   logic                  r_hold_busy;
   logic                  r_oe_tgt;
   logic                  r_first_pend;
   logic                  r_sda_oe, r_active, r_rx_valid, r_rx_first;
   logic                  r_rd_req, r_overrun;
   logic [7:0]            r_rx_data;
   logic [IDX_W-1:0]      r_match_idx;

   logic                  w_scl_rise, w_scl_fall, w_start, w_stop;
   logic                  w_byte_done, w_accept;
   logic [NUM_ADDR-1:0]   w_slot_hit;
   logic                  w_hit;
   logic [IDX_W-1:0]      w_hit_idx;
   logic                  w_kill, w_addr_ack, w_rd_pulse, w_load_byte;
   logic                  w_ovr_pulse, w_oe_tgt, w_cnt_clr;

   assign w_scl_rise  = ~r_scl_q & scl_s;
   assign w_scl_fall  = r_scl_q & ~scl_s;
   assign w_start     = scl_s & r_scl_q & r_sda_q & ~sda_s;
   assign w_stop      = scl_s & r_scl_q & ~r_sda_q & sda_s;
   assign w_byte_done = w_scl_fall & (r_bit_cnt == 3'd7);
   // A byte can be taken when the output slot is empty or being emptied now
   assign w_accept    = ~r_rx_valid | rx_ready;
   assign w_hit       = |w_slot_hit;

   // Per-slot address compare, then lowest enabled matching slot wins
   always_comb begin
      w_slot_hit = '0;
      w_hit_idx  = '0;
      for (int i = 0; i < NUM_ADDR; i++) begin
         w_slot_hit[i] = addr_en[i] & (addr_cfg[7*i +: 7] == r_shift[7:1]);
      end
      for (int i = NUM_ADDR - 1; i >= 0; i--) begin
         w_hit_idx = w_slot_hit[i] ? IDX_W'(i) : w_hit_idx;
      end
   end

   // Next-state and decision logic; STOP, disable, repeated START take priority
   always_comb begin
      w_state_nxt = r_state;
      w_kill      = 1'b0;
      w_addr_ack  = 1'b0;
      w_rd_pulse  = 1'b0;
      w_load_byte = 1'b0;
      w_ovr_pulse = 1'b0;
      w_oe_tgt    = 1'b0;
      w_cnt_clr   = 1'b0;
      if (w_stop) begin
         w_state_nxt = ST_IDLE;
         w_kill      = 1'b1;
      end else if ((r_state != ST_IDLE) && !enable) begin
         w_state_nxt = ST_IGNORE;
         w_kill      = 1'b1;
      end else if ((r_state != ST_IDLE) && w_start) begin
         w_state_nxt = ST_ADDR_LO;
         w_kill      = 1'b1;
         w_cnt_clr   = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start && enable) begin
                  w_state_nxt = ST_ADDR_LO;
                  w_cnt_clr   = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_ADDR_LO: w_state_nxt = w_scl_rise ? ST_ADDR_HI : ST_ADDR_LO;
            ST_ADDR_HI: begin
               if (w_byte_done) begin
                  if (w_hit) begin
                     w_state_nxt = ST_AACK_LO;
                     w_addr_ack  = 1'b1;
                     w_oe_tgt    = 1'b1;
                     w_rd_pulse  = r_shift[0];
                  end else begin
                     w_state_nxt = ST_IGNORE;
                  end
               end else begin
                  w_state_nxt = w_scl_fall ? ST_ADDR_LO : ST_ADDR_HI;
               end
            end
            ST_AACK_LO: w_state_nxt = w_scl_rise ? ST_AACK_HI : ST_AACK_LO;
            ST_AACK_HI: begin
               if (w_scl_fall) begin
                  w_state_nxt = r_rw ? ST_IGNORE : ST_DATA_LO;
               end else begin
                  w_state_nxt = ST_AACK_HI;
               end
            end
            ST_DATA_LO: w_state_nxt = w_scl_rise ? ST_DATA_HI : ST_DATA_LO;
            ST_DATA_HI: begin
               if (w_byte_done) begin
                  w_state_nxt = ST_DACK_LO;
                  w_load_byte = w_accept;
                  w_oe_tgt    = w_accept;
                  w_ovr_pulse = ~w_accept;
               end else begin
                  w_state_nxt = w_scl_fall ? ST_DATA_LO : ST_DATA_HI;
               end
            end
            ST_DACK_LO: w_state_nxt = w_scl_rise ? ST_DACK_HI : ST_DACK_LO;
            ST_DACK_HI: w_state_nxt = w_scl_fall ? ST_DATA_LO : ST_DACK_HI;
            ST_IGNORE:  w_state_nxt = ST_IGNORE;
            default:    w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Previous SCL/SDA samples for edge and condition detection
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         r_scl_q <= 1'b1;
         r_sda_q <= 1'b1;
      end else begin
         r_scl_q <= scl_s;
         r_sda_q <= sda_s;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Bit counter, MSB-first shift register and captured R/W bit
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'd0;
         r_rw      <= 1'b0;
      end else begin
         if (w_cnt_clr) begin
            r_bit_cnt <= 3'd0;
         end else if (w_scl_fall && ((r_state == ST_ADDR_HI) || (r_state == ST_DATA_HI))) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         if (w_scl_rise && ((r_state == ST_ADDR_LO) || (r_state == ST_DATA_LO))) begin
            r_shift <= {r_shift[6:0], sda_s};
         end
         if (w_addr_ack) begin
            r_rw <= r_shift[0];
         end
      end
   end

   // SDA drive: every SCL fall arms a delayed update, bus events release at once
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         r_sda_oe    <= 1'b0;
         r_hold_busy <= 1'b0;
         r_hold_cnt  <= '0;
         r_oe_tgt    <= 1'b0;
      end else if (w_kill) begin
         r_sda_oe    <= 1'b0;
         r_hold_busy <= 1'b0;
      end else if (w_scl_fall) begin
         r_hold_busy <= 1'b1;
         r_hold_cnt  <= HOLD_CNT_W'(1);
         r_oe_tgt    <= w_oe_tgt;
      end else if (r_hold_busy) begin
         if (r_hold_cnt >= hold_cycles) begin
            r_sda_oe    <= r_oe_tgt;
            r_hold_busy <= 1'b0;
         end else begin
            r_hold_cnt  <= r_hold_cnt + HOLD_CNT_W'(1);
         end
      end
   end

   // Received-byte hand-off; independent of bus state once loaded
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         r_rx_data    <= 8'd0;
         r_rx_valid   <= 1'b0;
         r_rx_first   <= 1'b0;
         r_first_pend <= 1'b0;
      end else begin
         if (w_load_byte) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
            r_rx_first <= r_first_pend;
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
         if (w_addr_ack) begin
            r_first_pend <= ~r_shift[0];
         end else if (w_load_byte) begin
            r_first_pend <= 1'b0;
         end
      end
   end

   // Status outputs: activity flag, matched slot and event pulses
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         r_active    <= 1'b0;
         r_match_idx <= '0;
         r_rd_req    <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_active  <= (w_state_nxt != ST_IDLE);
         r_rd_req  <= w_rd_pulse;
         r_overrun <= w_ovr_pulse;
         if (w_addr_ack) begin
            r_match_idx <= w_hit_idx;
         end
      end
   end

   assign sda_oe    = r_sda_oe;
   assign active    = r_active;
   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign rx_first  = r_rx_first;
   assign match_idx = r_match_idx;
   assign rd_req    = r_rd_req;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_i2c_rx_ctrl.sv
// Self-checking bench for i2c_rx_ctrl: bit-level I2C master plus a
// transaction-level expectation model (address slots, byte acceptance).
module tb_i2c_rx_ctrl;

   localparam int NA   = 3;
   localparam int HW   = 4;
   localparam int IW   = 2;
   localparam int HALF = 10;

   logic            clk = 1'b0;
   logic            rst_an = 1'b0;
   logic            enable = 1'b0;
   logic            scl_m = 1'b1;
   logic            sda_m = 1'b1;
   logic            rx_ready = 1'b1;
   logic [6:0]      cfg_m [NA];
   logic [NA-1:0]   en_m = '0;
   logic [7*NA-1:0] addr_cfg;
   logic [HW-1:0]   hold_cycles = '0;

   logic            sda_oe, active, rx_valid, rx_first, rd_req, overrun;
   logic [7:0]      rx_data;
   logic [IW-1:0]   match_idx;

   int              total = 0;
   int              bad = 0;
   int              n_rd = 0;
   int              n_ovr = 0;
   int              exp_ovr = 0;
   logic            m_valid = 1'b0;
   logic [8:0]      exp_q [$];
   logic [8:0]      obs_q [$];
   logic [7:0]      dbuf [4];

   assign addr_cfg = {cfg_m[2], cfg_m[1], cfg_m[0]};

   i2c_rx_ctrl #(.NUM_ADDR(NA), .HOLD_CNT_W(HW), .IDX_W(IW)) u_dut (
      .clk(clk), .rst_an(rst_an), .enable(enable),
      .scl_s(scl_m), .sda_s(sda_m),
      .addr_cfg(addr_cfg), .addr_en(en_m), .hold_cycles(hold_cycles),
      .sda_oe(sda_oe), .active(active),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_first(rx_first), .match_idx(match_idx),
      .rd_req(rd_req), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Output monitor: collects handshaken bytes and counts pulse cycles
   always @(negedge clk) begin
      if (rx_valid && rx_ready) obs_q.push_back({rx_first, rx_data});
      if (rd_req) n_rd++;
      if (overrun) n_ovr++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Lowest enabled slot whose address equals a, else -1
   function automatic int exp_slot(input logic [6:0] a);
      for (int i = 0; i < NA; i++) begin
         if (en_m[i] && (cfg_m[i] == a)) return i;
      end
      return -1;
   endfunction

   function automatic int exp_dly(input int hold);
      return (hold == 0) ? 1 : hold;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic bus_start();
      sda_m = 1'b1; tick(HALF);
      scl_m = 1'b1; tick(HALF);
      sda_m = 1'b0; tick(HALF);
      scl_m = 1'b0; tick(HALF);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; tick(HALF);
      scl_m = 1'b1; tick(HALF);
      sda_m = 1'b1; tick(HALF);
   endtask

   task automatic clk_bit(input logic b);
      sda_m = b;    tick(HALF);
      scl_m = 1'b1; tick(HALF);
      scl_m = 1'b0; tick(HALF);
   endtask

   // After an SCL fall: first sample index where sda_oe==fin, and count of highs
   task automatic measure(input logic fin, output int first, output int n_hi);
      first = -1;
      n_hi  = 0;
      for (int j = 0; j < HALF; j++) begin
         tick(1);
         if (sda_oe) n_hi++;
         if (first < 0 && sda_oe == fin) first = j;
      end
   endtask

   task automatic send_byte_data(input logic [7:0] b, input logic ack, input int hold, input string tag);
      int f, nh;
      for (int i = 7; i >= 1; i--) clk_bit(b[i]);
      sda_m = b[0]; tick(HALF);
      scl_m = 1'b1; tick(HALF);
      scl_m = 1'b0;
      measure(1'b1, f, nh);
      if (ack) chk({tag, "_ack_dly"}, f, exp_dly(hold));
      else     chk({tag, "_nack_oe"}, nh, 0);
   endtask

   task automatic ack_clock(input logic ack, input int hold, input string tag);
      int f, nh;
      sda_m = 1'b1; tick(HALF);
      scl_m = 1'b1; tick(HALF);
      chk({tag, "_ack"}, sda_oe, ack);
      scl_m = 1'b0;
      measure(1'b0, f, nh);
      if (ack) chk({tag, "_rel_dly"}, f, exp_dly(hold));
      else     chk({tag, "_rel_oe"}, nh, 0);
   endtask

   task automatic xfer(input logic [6:0] a, input logic rw, input int nb, input int hold);
      int   slot, rd0;
      logic ok_a, wr_ok, acc, first;
      slot  = exp_slot(a);
      ok_a  = (slot >= 0);
      wr_ok = ok_a && !rw;
      hold_cycles = HW'(hold);
      rd0 = n_rd;
      bus_start();
      chk("act_start", active, 1);
      send_byte_data({a, rw}, ok_a, hold, "addr");
      ack_clock(ok_a, hold, "addr");
      chk("act_mid", active, 1);
      chk("rd_req", n_rd - rd0, (ok_a && rw) ? 1 : 0);
      if (ok_a) chk("idx", int'(match_idx), slot);
      first = 1'b1;
      for (int b = 0; b < nb; b++) begin
         acc = wr_ok && (!m_valid || rx_ready);
         send_byte_data(dbuf[b], acc, hold, "data");
         ack_clock(acc, hold, "data");
         if (acc) begin
            exp_q.push_back({first, dbuf[b]});
            first = 1'b0;
            if (!rx_ready) m_valid = 1'b1;
         end else if (wr_ok) begin
            exp_ovr++;
         end
      end
      bus_stop();
      chk("act_stop", active, 0);
      chk("overrun", n_ovr, exp_ovr);
   endtask

   task automatic check_rx();
      chk("rx_cnt", obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         chk("rx_byte", obs_q.pop_front(), exp_q.pop_front());
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int          rd0, hold, nb;
      logic [6:0]  a;
      logic        rw;
      cfg_m[0] = 7'h3B; cfg_m[1] = 7'h3A; cfg_m[2] = 7'h3A;
      en_m = 3'b111;
      tick(3);
      // Reset state
      chk("rst_oe", sda_oe, 0);       chk("rst_active", active, 0);
      chk("rst_valid", rx_valid, 0);  chk("rst_data", rx_data, 0);
      chk("rst_first", rx_first, 0);  chk("rst_idx", match_idx, 0);
      chk("rst_rd", rd_req, 0);       chk("rst_ovr", overrun, 0);
      rst_an = 1'b1;
      enable = 1'b1;
      tick(3);

      // Basic write, slot 1 wins over duplicate slot 2
      dbuf[0] = 8'hA5; dbuf[1] = 8'h5A;
      xfer(7'h3A, 1'b0, 2, 2);
      check_rx();
      // Unmatched address
      dbuf[0] = 8'h77;
      xfer(7'h11, 1'b0, 1, 2);
      check_rx();
      // Consumer stalled: second byte overruns
      rx_ready = 1'b0;
      dbuf[0] = 8'hC3; dbuf[1] = 8'h3C;
      xfer(7'h3A, 1'b0, 2, 3);
      chk("hold_data", rx_data, 8'hC3);
      chk("hold_valid", rx_valid, 1);
      rx_ready = 1'b1;
      tick(3);
      m_valid = 1'b0;
      chk("drain_valid", rx_valid, 0);
      check_rx();

      // Partial byte, repeated START into a read
      hold_cycles = 4'd3;
      bus_start();
      send_byte_data({7'h3A, 1'b0}, 1'b1, 3, "t5w");
      ack_clock(1'b1, 3, "t5w");
      for (int i = 0; i < 4; i++) clk_bit(1'($urandom_range(0, 1)));
      rd0 = n_rd;
      bus_start();
      chk("t5_act", active, 1);
      send_byte_data({7'h3A, 1'b1}, 1'b1, 3, "t5r");
      ack_clock(1'b1, 3, "t5r");
      chk("t5_rd", n_rd - rd0, 1);
      send_byte_data(8'hFF, 1'b0, 3, "t5ign");
      ack_clock(1'b0, 3, "t5ign");
      chk("t5_ign_act", active, 1);
      bus_stop();
      chk("t5_stop", active, 0);
      check_rx();

      // Asynchronous reset while ACK is driven
      hold_cycles = 4'd1;
      bus_start();
      send_byte_data({7'h3A, 1'b0}, 1'b1, 1, "t6a");
      sda_m = 1'b1; tick(HALF);
      scl_m = 1'b1; tick(3);
      chk("t6_pre_oe", sda_oe, 1);
      #1 rst_an = 1'b0;
      #1 chk("t6_rst_oe", sda_oe, 0);
      chk("t6_rst_act", active, 0);
      #1 rst_an = 1'b1;
      m_valid = 1'b0;
      scl_m = 1'b0; tick(HALF);
      bus_stop();
      chk("t6_idle", active, 0);

      // Enable dropped mid-byte, re-enabled without resuming
      bus_start();
      send_byte_data({7'h3A, 1'b0}, 1'b1, 1, "t6b");
      ack_clock(1'b1, 1, "t6b");
      for (int i = 0; i < 3; i++) clk_bit(1'b1);
      enable = 1'b0;
      tick(2);
      chk("t6_dis_act", active, 1);
      enable = 1'b1;
      for (int i = 0; i < 5; i++) clk_bit(1'b0);
      ack_clock(1'b0, 1, "t6dis");
      send_byte_data(8'h96, 1'b0, 1, "t6ign");
      ack_clock(1'b0, 1, "t6ign");
      dbuf[0] = 8'h69;
      xfer(7'h3A, 1'b0, 1, 1);
      check_rx();

      // Randomised transactions; first two fix the hold delay at 5 then 0
      for (int t = 0; t < 14; t++) begin
         for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom);
         if (t < 2) begin
            a = 7'h3A; rw = 1'b0; nb = 1; hold = (t == 0) ? 5 : 0;
         end else begin
            for (int i = 0; i < NA; i++) cfg_m[i] = 7'($urandom_range(0, 127));
            en_m = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) cfg_m[2] = cfg_m[1];
            if ($urandom_range(0, 3) != 0) a = cfg_m[$urandom_range(0, NA - 1)];
            else                           a = 7'($urandom_range(0, 127));
            rw   = ($urandom_range(0, 3) == 0);
            nb   = $urandom_range(0, 3);
            hold = $urandom_range(0, 7);
         end
         xfer(a, rw, nb, hold);
         check_rx();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
